// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_bus_if
// Description : Write-port bus between the LED sequencer (master) and the
//               indicator-LED peripheral (slave).
//   bus_addr  4  command address (0x0 led1 on, 0x2 led2 on,
//                0x4 led1 off, 0x8 led2 off)
//   bus_cs    1  chip select, high only in an issue cycle
//   bus_wr    1  write strobe, equal to bus_cs
//   bus_rd    1  read strobe, always 0
// Revision    : 1.0  initial release
// ============================================================================
interface led_bus_if;
    logic [3:0] bus_addr;
    logic       bus_cs;
    logic       bus_wr;
    logic       bus_rd;

    modport master (output bus_addr, output bus_cs, output bus_wr, output bus_rd);
    modport slave  (input  bus_addr, input  bus_cs, input  bus_wr, input  bus_rd);
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Bus-master sequencer that blinks the indicator LEDs by issuing
//               single-cycle cs/wr strobes to the LED peripheral write port.
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        1-cycle run request, sampled only when idle
//   stop         abort request, sampled while busy
//   mode         00 led1, 01 led2, 10 alternate, 11 both (latched at start)
//   half_period  wait cycles per phase, 0 treated as 1 (latched at start)
//   count        full blinks per run, 0 = continuous (latched at start)
//   bus          led_bus_if master: bus_addr/bus_cs/bus_wr/bus_rd
//   busy         high whenever a run (or its shutdown) is in progress
//   done         1-cycle pulse in the first idle cycle after a run ends
// Revision    : 1.0  initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int PW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] half_period,
    input  logic [CW-1:0] count,
    led_bus_if.master     bus,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_A = 3'd1,
        ISSUE_B = 3'd2,
        WAIT    = 3'd3,
        SHUT_1  = 3'd4,
        SHUT_2  = 3'd5
    } state_t;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    state_t        state;
    phase_t        phase;
    logic [PW-1:0] timer;
    logic [CW-1:0] blinks;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] cfg_hp;
    logic [CW-1:0] cfg_count;
    logic [3:0]    addr_reg;
    logic          strobe;

    logic [CW-1:0] blinks_inc;
    logic [PW-1:0] hp_in_eff;
    logic          two_ops;

    assign blinks_inc = blinks + CW'(1);
    assign hp_in_eff  = (half_period == '0) ? PW'(1) : half_period;
    // Mode bit 1 selects the modes that touch both LEDs in every phase.
    assign two_ops    = cfg_mode[1];

    assign bus.bus_addr = addr_reg;
    assign bus.bus_cs   = strobe;
    assign bus.bus_wr   = strobe;
    assign bus.bus_rd   = 1'b0;

    // Command address for op slot 'second' of a phase in a given mode.
    function automatic logic [3:0] op_addr(input logic [1:0] m, input phase_t ph,
                                           input logic second);
        logic [3:0] a;
        a = 4'h0;
        unique case (m)
            2'b00:   a = (ph == PH_OFF) ? 4'h4 : 4'h0;
            2'b01:   a = (ph == PH_OFF) ? 4'h8 : 4'h2;
            2'b10:   a = second ? ((ph == PH_OFF) ? 4'h2 : 4'h8)
                                : ((ph == PH_OFF) ? 4'h4 : 4'h0);
            default: a = second ? ((ph == PH_OFF) ? 4'h8 : 4'h2)
                                : ((ph == PH_OFF) ? 4'h4 : 4'h0);
        endcase
        return a;
    endfunction

    // Outputs are registered: each branch sets the strobe/address that
    // belong to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= PH_ON;
            timer     <= '0;
            blinks    <= '0;
            cfg_mode  <= 2'b00;
            cfg_hp    <= PW'(1);
            cfg_count <= '0;
            addr_reg  <= 4'h0;
            strobe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            strobe   <= 1'b0;
            addr_reg <= 4'h0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        cfg_mode  <= mode;
                        cfg_hp    <= hp_in_eff;
                        cfg_count <= count;
                        phase     <= PH_ON;
                        blinks    <= '0;
                        state     <= ISSUE_A;
                        strobe    <= 1'b1;
                        addr_reg  <= op_addr(mode, PH_ON, 1'b0);
                        busy      <= 1'b1;
                    end
                end
                ISSUE_A: begin
                    if (stop) begin
                        state    <= SHUT_1;
                        strobe   <= 1'b1;
                        addr_reg <= 4'h4;
                    end else if (two_ops) begin
                        state    <= ISSUE_B;
                        strobe   <= 1'b1;
                        addr_reg <= op_addr(cfg_mode, phase, 1'b1);
                    end else begin
                        state <= WAIT;
                        timer <= cfg_hp - PW'(1);
                    end
                end
                ISSUE_B: begin
                    if (stop) begin
                        state    <= SHUT_1;
                        strobe   <= 1'b1;
                        addr_reg <= 4'h4;
                    end else begin
                        state <= WAIT;
                        timer <= cfg_hp - PW'(1);
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state    <= SHUT_1;
                        strobe   <= 1'b1;
                        addr_reg <= 4'h4;
                    end else if (timer != '0) begin
                        timer <= timer - PW'(1);
                    end else if (phase == PH_ON) begin
                        phase    <= PH_OFF;
                        state    <= ISSUE_A;
                        strobe   <= 1'b1;
                        addr_reg <= op_addr(cfg_mode, PH_OFF, 1'b0);
                    end else begin
                        // count==0 never matches, so a continuous run lets blinks wrap.
                        blinks <= blinks_inc;
                        if (cfg_count != '0 && blinks_inc == cfg_count) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            phase    <= PH_ON;
                            state    <= ISSUE_A;
                            strobe   <= 1'b1;
                            addr_reg <= op_addr(cfg_mode, PH_ON, 1'b0);
                        end
                    end
                end
                SHUT_1: begin
                    state    <= SHUT_2;
                    strobe   <= 1'b1;
                    addr_reg <= 4'h8;
                end
                SHUT_2: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl. A run is described as a
//               list of per-cycle expected outputs built from the blink rules
//               (ops per phase, wait length, blink count, stop shutdown) and
//               compared every cycle against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_seq_ctrl;
    localparam int PW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [PW-1:0] half_period = '0;
    logic [CW-1:0] count = '0;
    logic          busy;
    logic          done;

    led_bus_if bus ();

    led_seq_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .half_period (half_period),
        .count       (count),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cs;
        logic [3:0] addr;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       model_q[$];
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;
    int         cyc = 0;
    logic [3:0] op_tab [4][2][2];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected per-cycle outputs of one run, starting with the first cycle
    // after start is accepted. stop_j >= 0 means stop is seen in entry stop_j.
    task automatic build_run(input logic [1:0] m, input int hp, input int cnt, input int stop_j);
        int   hpe;
        int   nops;
        int   nph;
        exp_t e;
        hpe  = (hp == 0) ? 1 : hp;
        nops = m[1] ? 2 : 1;
        nph  = (cnt == 0) ? 40 : 2 * cnt;
        model_q.delete();
        for (int p = 0; p < nph; p++) begin
            for (int i = 0; i < nops; i++) begin
                e.cs = 1'b1; e.addr = op_tab[m][p % 2][i]; e.busy = 1'b1; e.done = 1'b0;
                model_q.push_back(e);
            end
            for (int w = 0; w < hpe; w++) begin
                e = '0; e.busy = 1'b1;
                model_q.push_back(e);
            end
        end
        if (stop_j >= 0) begin
            while (model_q.size() > stop_j + 1) void'(model_q.pop_back());
            e = '0; e.cs = 1'b1; e.addr = 4'h4; e.busy = 1'b1;
            model_q.push_back(e);
            e.addr = 4'h8;
            model_q.push_back(e);
        end
        e = '0; e.done = 1'b1;
        model_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check_val({name, "_drain"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    // Drives one run; config inputs are scrambled after start to show they are latched.
    task automatic run_test(input string name, input logic [1:0] m, input int hp, input int cnt,
                            input int stop_j, input int sp_j);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; mode = m; half_period = PW'(hp); count = CW'(cnt);
        e = '0;
        exp_q.push_back(e);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; half_period = PW'(hp + 7); count = CW'(cnt + 3);
        if (stop_j >= 0) begin
            repeat (stop_j) @(posedge clk);
            #1 stop = 1'b1;
            @(posedge clk); #1 stop = 1'b0;
        end else if (sp_j > 0) begin
            repeat (sp_j) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_drain(name);
    endtask

    // Single compare process: idle is expected whenever no run is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cyc++;
                e = '0;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                check_val($sformatf("outputs_cyc%0d", cyc),
                          {23'd0, bus.bus_cs, bus.bus_wr, bus.bus_rd, bus.bus_addr, busy, done},
                          {23'd0, e.cs, e.cs, 1'b0, e.addr, e.busy, e.done});
            end
        end
    end

    initial begin
        op_tab = '{ '{'{4'h0, 4'h0}, '{4'h4, 4'h0}},
                    '{'{4'h2, 4'h0}, '{4'h8, 4'h0}},
                    '{'{4'h0, 4'h8}, '{4'h4, 4'h2}},
                    '{'{4'h0, 4'h2}, '{4'h4, 4'h8}} };

        // Reset asserted with start held high.
        #2 rst = 1'b0; start = 1'b1;
        #3 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_cs",   bus.bus_cs,   0);
        check_val("reset_addr", bus.bus_addr, 0);
        check_val("reset_busy", busy,         0);
        check_val("reset_done", done,         0);
        start = 1'b0; rst = 1'b1;
        repeat (4) @(posedge clk);

        // mode00 hp=3 count=2: strobes 0,4,0,4 four cycles apart.
        build_run(2'b00, 3, 2, -1);
        check_val("model_t2_len",   model_q.size(),    17);
        check_val("model_t2_addr4", model_q[4].addr,   4);
        check_val("model_t2_done",  model_q[16].done,  1);
        check_val("model_t2_busy",  model_q[16].busy,  0);
        run_test("t2", 2'b00, 3, 2, -1, 0);

        // mode10 hp=2 count=1: 0,8, wait 2, 4,2, wait 2, done.
        build_run(2'b10, 2, 1, -1);
        check_val("model_t3_len",   model_q.size(),  9);
        check_val("model_t3_addr1", model_q[1].addr, 8);
        check_val("model_t3_addr5", model_q[5].addr, 2);
        run_test("t3", 2'b10, 2, 1, -1, 0);

        // mode11 hp=0 continuous, stop in the WAIT of the fifth phase.
        build_run(2'b11, 0, 0, 14);
        check_val("model_t4_len",    model_q.size(),   18);
        check_val("model_t4_shut1",  model_q[15].addr, 4);
        check_val("model_t4_shut2",  model_q[16].addr, 8);
        run_test("t4", 2'b11, 0, 0, 14, 0);

        // mode11 stop in the first ISSUE_A: 0 completes, 2 never issued.
        build_run(2'b11, 5, 2, 0);
        check_val("model_t5_len",  model_q.size(),  4);
        check_val("model_t5_addr", model_q[1].addr, 4);
        run_test("t5", 2'b11, 5, 2, 0, 0);

        // mode01 hp=1 count=3 plain run.
        build_run(2'b01, 1, 3, -1);
        run_test("t_m01", 2'b01, 1, 3, -1, 0);

        // Stop in the very last WAIT cycle still shuts down via 4,8.
        build_run(2'b00, 2, 1, 5);
        run_test("t_stop_last", 2'b00, 2, 1, 5, 0);

        // start and stop together in IDLE: nothing happens.
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (6) @(posedge clk);

        // start pulsed mid-run leaves timing unchanged.
        build_run(2'b01, 2, 2, -1);
        run_test("t6", 2'b01, 2, 2, -1, 3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
